// File: rtl/restador_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default width.
`ifndef RESTADOR_SERIAL_PKG_SV
`define RESTADOR_SERIAL_PKG_SV
package restador_serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage
`endif

// File: rtl/restador_completo.sv
// Combinational 1-bit full subtractor: d = a - b - bi, bo = borrow out.
module restador_completo #(
  parameter int PwrC = 0
) (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  // PwrC only tags the cell for power characterisation; both arms are the same logic.
  if (PwrC >= 0) begin : g_cell
    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);
  end else begin : g_cell_alt
    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);
  end

endmodule

// File: rtl/restador_serial.sv
// Bit-serial ripple subtractor: d = a - b - bi, one bit per clock, LSB first.
// Handshake: start is sampled only while idle (busy=0); the operands are
// captured on that edge, busy stays high until the result is flagged, and
// done is a one-cycle pulse during which d/bo/ovf already hold the new result.
module restador_serial
  import restador_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int PwrC  = 0
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rega_q, rega_d;
  logic [WIDTH-1:0] regb_q, regb_d;
  logic             br_q, br_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             bo_q, bo_d;
  logic             ovf_q, ovf_d;

  logic             cell_d, cell_bo;
  logic [WIDTH-1:0] res_next;

  restador_completo #(.PwrC(PwrC)) u_cell (
    .a  (rega_q[0]),
    .b  (regb_q[0]),
    .bi (br_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // Partial result with the current difference bit shifted in at the top.
  assign res_next = {cell_d, res_q};

  // State, datapath and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rega_q  <= '0;
      regb_q  <= '0;
      br_q    <= 1'b0;
      res_q   <= '0;
      dout_q  <= '0;
      bo_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rega_q  <= rega_d;
      regb_q  <= regb_d;
      br_q    <= br_d;
      res_q   <= res_d;
      dout_q  <= dout_d;
      bo_q    <= bo_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic: capture in IDLE, one bit per edge in RUN, single DONE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rega_d  = rega_q;
    regb_d  = regb_q;
    br_d    = br_q;
    res_d   = res_q;
    dout_d  = dout_q;
    bo_d    = bo_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rega_d  = a;
          regb_d  = b;
          br_d    = bi;
          cnt_d   = '0;
          res_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        rega_d = rega_q >> 1;
        regb_d = regb_q >> 1;
        br_d   = cell_bo;
        res_d  = res_next[WIDTH-1:1];
        if (cnt_q == LAST) begin
          // Last bit: the cell inputs are the operand sign bits.
          dout_d  = res_next;
          bo_d    = cell_bo;
          ovf_d   = (rega_q[0] != regb_q[0]) & (cell_d != rega_q[0]);
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign d    = dout_q;
  assign bo   = bo_q;
  assign ovf  = ovf_q;

endmodule
